// File: rtl/pmic_main.sv
// pmic_main: four-rail power sequencer.
// Three asynchronous board switches are synchronized and decoded into an
// operating mode. The rail-enable vector walks one rail at a time toward
// that mode's thermometer mask, with STEP_DELAY cycles between steps.
// Rails are enabled in ascending order and disabled in descending order.
module pmic_main #(
  parameter int STEP_DELAY = 6,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_sw,
  input  logic       lb_sw,
  input  logic       lp_sw,
  output logic [3:0] led,
  output logic [3:0] SSG_EN
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_LB     = 2'd1,
    MODE_LP     = 2'd2,
    MODE_ACTIVE = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DELAY - 1);

  // Switch bundle: bit 0 = on, bit 1 = low battery, bit 2 = low power.
  logic [2:0] sw_raw;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  assign sw_raw = {lp_sw, lb_sw, on_sw};

  // Two-flop synchronizer per switch; switches are not debounced.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= sw_raw[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  mode_t      mode;
  logic [3:0] target;
  logic [2:0] mode_led;

  // Priority decode: off beats low battery, low battery beats low power.
  always_comb begin
    mode     = MODE_ACTIVE;
    target   = 4'b1111;
    mode_led = 3'b001;
    if (!sync2_reg[0]) begin
      mode     = MODE_OFF;
      target   = 4'b0000;
      mode_led = 3'b000;
    end else if (sync2_reg[1]) begin
      mode     = MODE_LB;
      target   = 4'b0001;
      mode_led = 3'b100;
    end else if (sync2_reg[2]) begin
      mode     = MODE_LP;
      target   = 4'b0011;
      mode_led = 3'b010;
    end
  end

  logic [3:0]       ssg_reg, ssg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       led_reg, led_next;
  logic             busy;

  // Sequencer state register and status LEDs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ssg_reg <= 4'b0000;
      cnt_reg <= '0;
      led_reg <= 4'b0000;
    end else begin
      ssg_reg <= ssg_next;
      cnt_reg <= cnt_next;
      led_reg <= led_next;
    end
  end

  // Step timing and direction. The counter is kept across target changes,
  // so a reversal mid-ramp takes effect on the very next step.
  always_comb begin
    ssg_next = ssg_reg;
    cnt_next = '0;
    busy     = (ssg_reg != target);
    if (busy) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        // Thermometer codes compare numerically, so magnitude gives direction.
        if (ssg_reg < target) begin
          ssg_next = {ssg_reg[2:0], 1'b1};
        end else begin
          ssg_next = {1'b0, ssg_reg[3:1]};
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    led_next = {busy, mode_led};
  end

  assign SSG_EN = ssg_reg;
  assign led    = led_reg;

endmodule

// File: tb/tb_pmic_main.sv
// Testbench for pmic_main: directed mode walks from the test plan followed by
// randomized switch activity, all checked cycle by cycle against a
// rail-count reference model.
module tb_pmic_main;

  localparam int STEP = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       on_sw = 1'b0;
  logic       lb_sw = 1'b0;
  logic       lp_sw = 1'b0;
  logic [3:0] led;
  logic [3:0] SSG_EN;

  int errors = 0;
  int checks = 0;

  pmic_main #(.STEP_DELAY(STEP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .on_sw(on_sw), .lb_sw(lb_sw), .lp_sw(lp_sw),
    .led(led), .SSG_EN(SSG_EN)
  );

  always #5 clk = ~clk;

  // Reference model: number of rails on, step timer, switch delay line.
  int         m_lvl = 0;
  int         m_cnt = 0;
  logic [2:0] m_s1 = '0;
  logic [2:0] m_s2 = '0;
  logic [3:0] m_led = '0;

  function automatic int tgt_lvl(input logic [2:0] s);
    if (!s[0]) return 0;
    if (s[1])  return 1;
    if (s[2])  return 2;
    return 4;
  endfunction

  function automatic logic [2:0] mode_led(input logic [2:0] s);
    if (!s[0]) return 3'b000;
    if (s[1])  return 3'b100;
    if (s[2])  return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [3:0] rails(input int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_cnt = 0; m_s1 = '0; m_s2 = '0; m_led = '0;
  endtask

  // One clock: advance the model with pre-edge values, then compare.
  task automatic step();
    int t;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      t = tgt_lvl(m_s2);
      m_led = {(m_lvl != t), mode_led(m_s2)};
      if (m_lvl == t) m_cnt = 0;
      else if (m_cnt == STEP - 1) begin
        m_cnt = 0;
        m_lvl = (m_lvl < t) ? m_lvl + 1 : m_lvl - 1;
      end else m_cnt++;
      m_s2 = m_s1;
      m_s1 = {lp_sw, lb_sw, on_sw};
    end
    #1;
    chk("ssg_en", SSG_EN, rails(m_lvl));
    chk("led", led, m_led);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until SSG_EN equals val; a blown budget counts as a failure.
  task automatic run_until(input logic [3:0] val, input int limit, output int n);
    n = 0;
    while (SSG_EN !== val && n < limit) begin
      step();
      n++;
    end
    if (SSG_EN !== val) chk("timeout", SSG_EN, val);
  endtask

  // Asynchronous reset assertion between clock edges.
  task automatic async_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_ssg", SSG_EN, 4'b0000);
    chk("rst_led", led, 4'b0000);
  endtask

  initial begin
    int n;
    logic [3:0] prev;
    logic seen_full;

    // Reset state
    #2;
    chk("por_ssg", SSG_EN, 4'b0000);
    chk("por_led", led, 4'b0000);
    run(3);
    reset = 1'b1;
    run(2);

    // Power cycle: first step 8 cycles after the switch edge
    on_sw = 1'b1;
    run_until(4'b0001, 40, n);
    chk("first_step_lat", 4'(n), 4'd8);
    chk("ramp_busy", led, 4'b1001);
    run_until(4'b1111, 40, n);
    chk("ramp_rest_lat", 4'(n), 4'(3 * STEP));
    run(2);
    chk("active_led", led, 4'b0001);
    on_sw = 1'b0;
    run_until(4'b0000, 60, n);
    chk("pdown_lat", 4'(n), 4'(2 + 4 * STEP));
    run(2);
    chk("off_led", led, 4'b0000);

    // ACTIVE -> LP -> LB -> LP -> ACTIVE
    on_sw = 1'b1;
    run(30);
    lp_sw = 1'b1;
    run(18);
    chk("lp_ssg", SSG_EN, 4'b0011);
    chk("lp_led", led, 4'b0010);
    lb_sw = 1'b1;
    run(12);
    chk("lb_ssg", SSG_EN, 4'b0001);
    chk("lb_led", led, 4'b0100);
    lb_sw = 1'b0;
    run(12);
    chk("lb2lp_ssg", SSG_EN, 4'b0011);
    lp_sw = 1'b0;
    run(18);
    chk("lp2act_ssg", SSG_EN, 4'b1111);
    chk("lp2act_led", led, 4'b0001);

    // Overlapping switches: ACTIVE -> LB -> LP -> LB -> ACTIVE
    lb_sw = 1'b1;
    run(24);
    chk("ov_lb", SSG_EN, 4'b0001);
    seen_full = 1'b0;
    lp_sw = 1'b1;
    run(2);
    lb_sw = 1'b0;
    for (int i = 0; i < 16; i++) begin step(); if (SSG_EN == 4'b1111) seen_full = 1'b1; end
    chk("ov_lp", SSG_EN, 4'b0011);
    lb_sw = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); if (SSG_EN == 4'b1111) seen_full = 1'b1; end
    chk("ov_lb2", SSG_EN, 4'b0001);
    chk("ov_no_active", {3'b000, seen_full}, 4'b0000);
    lb_sw = 1'b0;
    lp_sw = 1'b0;
    run(26);
    chk("ov_final", SSG_EN, 4'b1111);

    // LB -> OFF, then LP -> OFF
    lb_sw = 1'b1;
    run(24);
    on_sw = 1'b0;
    run(8);
    chk("lb_off_ssg", SSG_EN, 4'b0000);
    run(2);
    chk("lb_off_led", led, 4'b0000);
    lb_sw = 1'b0;
    lp_sw = 1'b1;
    on_sw = 1'b1;
    run(20);
    chk("lp_up", SSG_EN, 4'b0011);
    on_sw = 1'b0;
    run(14);
    chk("lp_off", SSG_EN, 4'b0000);
    lp_sw = 1'b0;

    // Reset mid-ramp, then restart from 0000
    on_sw = 1'b1;
    run_until(4'b0011, 40, n);
    async_reset();
    run(2);
    reset = 1'b1;
    run_until(4'b0001, 40, n);
    chk("rerun_lat", 4'(n), 4'd8);
    run(20);
    chk("rerun_full", SSG_EN, 4'b1111);

    // Reversal mid-ramp
    on_sw = 1'b0;
    run(30);
    on_sw = 1'b1;
    run_until(4'b0011, 40, n);
    on_sw = 1'b0;
    prev = SSG_EN;
    n = 0;
    while (SSG_EN === prev && n < 20) begin step(); n++; end
    chk("rev_step1", SSG_EN, 4'b0001);
    run(STEP);
    chk("rev_step2", SSG_EN, 4'b0000);

    // Randomized switch activity
    for (int it = 0; it < 300; it++) begin
      on_sw = ($urandom_range(0, 3) != 0);
      lb_sw = $urandom_range(0, 1);
      lp_sw = $urandom_range(0, 1);
      if ($urandom_range(0, 24) == 0) begin
        async_reset();
        run($urandom_range(1, 3));
        reset = 1'b1;
      end
      run($urandom_range(1, 35));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
